// File: rtl/spir.sv
// SPI-to-register bridge: 48-bit mode-0 frames (16-bit header + 32 data bits)
// become single-cycle register read/write strobes in the clk domain.
module spir (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_di,
    output logic        spi_do,
    output logic        r_valid,
    output logic        r_wen,
    output logic [11:0] r_addr,
    output logic [31:0] r_wdata,
    input  logic [31:0] r_rdata
);
    typedef enum logic [1:0] {HDR, DATA, DONE} state_t;

    logic [2:0]  sclk_q;
    logic [1:0]  ncs_q;
    logic [1:0]  di_q;
    logic [1:0]  fill;
    logic        armed;
    state_t      state;
    logic [5:0]  cnt;
    logic [15:0] hdr;
    logic [31:0] wsr;
    logic [31:0] rsr;
    logic        rd_frame;

    logic        rise, fall, ncs, di;
    logic [15:0] hdr_nx;
    logic [31:0] wsr_nx;

    assign rise   = sclk_q[1] & ~sclk_q[2];
    assign fall   = ~sclk_q[1] & sclk_q[2];
    assign ncs    = ncs_q[1];
    assign di     = di_q[1];
    assign hdr_nx = {hdr[14:0], di};
    assign wsr_nx = {wsr[30:0], di};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sclk_q   <= 3'b000;
            ncs_q    <= 2'b11;
            di_q     <= 2'b00;
            fill     <= 2'b00;
            armed    <= 1'b0;
            state    <= HDR;
            cnt      <= 6'd0;
            hdr      <= 16'd0;
            wsr      <= 32'd0;
            rsr      <= 32'd0;
            rd_frame <= 1'b0;
            spi_do   <= 1'b0;
            r_valid  <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= 12'd0;
            r_wdata  <= 32'd0;
        end else begin
            sclk_q  <= {sclk_q[1:0], spi_clk};
            ncs_q   <= {ncs_q[0], spi_ncs};
            di_q    <= {di_q[0], spi_di};
            fill    <= {fill[0], 1'b1};
            r_valid <= 1'b0;

            // The synchroniser's reset value reads as "high"; only trust it
            // once real samples have filled both stages.
            if (fill[1] && ncs)
                armed <= 1'b1;

            if (r_valid && !r_wen)
                rsr <= r_rdata;

            if (ncs || !armed) begin
                state  <= HDR;
                cnt    <= 6'd0;
                spi_do <= 1'b0;
            end else begin
                case (state)
                    HDR: begin
                        spi_do <= 1'b0;
                        if (rise) begin
                            hdr <= hdr_nx;
                            cnt <= cnt + 6'd1;
                            if (cnt == 6'd15) begin
                                state    <= DATA;
                                r_addr   <= hdr_nx[11:0];
                                rd_frame <= ~hdr_nx[15];
                                if (!hdr_nx[15]) begin
                                    r_valid <= 1'b1;
                                    r_wen   <= 1'b0;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (rise) begin
                            wsr <= wsr_nx;
                            cnt <= cnt + 6'd1;
                            if (cnt == 6'd47) begin
                                state <= DONE;
                                if (!rd_frame) begin
                                    r_wdata <= wsr_nx;
                                    r_valid <= 1'b1;
                                    r_wen   <= 1'b1;
                                end
                            end
                        end
                        // Read word was captured well before the first data-phase fall.
                        if (fall && rd_frame) begin
                            spi_do <= rsr[31];
                            rsr    <= {rsr[30:0], 1'b0};
                        end
                    end
                    default: spi_do <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spir.sv
// Self-checking bench for spir: table of frames, hand-written reset/arming
// sequence and randomized frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_spir;
    localparam int HP = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_ncs = 1'b1;
    logic        spi_di = 1'b0;
    logic        spi_do;
    logic        r_valid;
    logic        r_wen;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    spir dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_ncs(spi_ncs),
        .spi_di(spi_di), .spi_do(spi_do), .r_valid(r_valid), .r_wen(r_wen),
        .r_addr(r_addr), .r_wdata(r_wdata), .r_rdata(r_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdval(input logic [11:0] a);
        if (a == 12'hC01) return 32'h0080_0001;
        return {a, 20'h0} ^ 32'h9E37_79B9 ^ {20'h0, a};
    endfunction

    assign r_rdata = rdval(r_addr);

    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    strobe_t strobes[$];
    int      vectors = 0;
    int      miscompares = 0;
    int      width_err = 0;
    logic    last_valid = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [11:0] m_addr = '0;

    always @(negedge clk) begin
        if (r_valid) strobes.push_back('{r_wen, r_addr, r_wdata});
        if (r_valid && last_valid) width_err++;
        last_valid = r_valid;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clock nbits mode-0 bits; miso collects what was on spi_do before rises 17..48
    // of a read frame, do_bad counts nonzero spi_do anywhere else.
    task automatic shift(input logic [47:0] fb, input int nbits, input bit is_read,
                         output logic [31:0] miso, output int do_bad);
        miso = '0;
        do_bad = 0;
        for (int j = 1; j <= nbits; j++) begin
            spi_di = (j <= 48) ? fb[48-j] : 1'($urandom);
            tick(HP);
            if (is_read && j >= 17 && j <= 48) miso = {miso[30:0], spi_do};
            else if (spi_do !== 1'b0) do_bad++;
            spi_clk = 1'b1;
            tick(HP);
            spi_clk = 1'b0;
        end
        tick(HP);
    endtask

    task automatic run_frame(input logic [15:0] h, input logic [31:0] d, input int nbits,
                             input int gap, input int exp_n);
        logic [31:0] miso;
        int          do_bad;
        bit          is_read;
        is_read = !h[15];
        strobes.delete();
        spi_ncs = 1'b0;
        shift({h, d}, nbits, is_read, miso, do_bad);
        spi_ncs = 1'b1;
        spi_di = 1'b0;
        chk("strobe_count", 64'(strobes.size()), 64'(exp_n));
        if (nbits >= 16) m_addr = h[11:0];
        if (!is_read && nbits >= 48) m_wdata = d;
        if (exp_n == 1 && strobes.size() == 1) begin
            chk("strobe_wen", 64'(strobes[0].wen), 64'(!is_read));
            chk("strobe_addr", 64'(strobes[0].addr), 64'(h[11:0]));
            if (!is_read) chk("strobe_wdata", 64'(strobes[0].wdata), 64'(d));
        end
        if (is_read && nbits >= 48) chk("miso_data", 64'(miso), 64'(rdval(h[11:0])));
        chk("spi_do_zero", 64'(do_bad), 64'd0);
        chk("r_addr_held", 64'(r_addr), 64'(m_addr));
        chk("r_wdata_held", 64'(r_wdata), 64'(m_wdata));
        tick(gap);
        chk("spi_do_idle", 64'(spi_do), 64'd0);
    endtask

    typedef struct {
        logic [15:0] h;
        logic [31:0] d;
        int          nbits;
        int          gap;
        int          exp_n;
    } vec_t;

    initial begin
        vec_t        tbl[9];
        logic [31:0] miso;
        int          do_bad;

        tbl[0] = '{16'h8C04, 32'hDEAD_BEEF, 48, 8, 1};
        tbl[1] = '{16'h0C01, 32'h0000_0000, 48, 8, 1};
        tbl[2] = '{16'h8123, 32'h1111_1111, 30, 8, 0};
        tbl[3] = '{16'h8801, 32'h1234_5678, 48, 8, 1};
        tbl[4] = '{16'h8F0F, 32'hA5A5_A5A5, 56, 8, 1};
        tbl[5] = '{16'h0C00, 32'hFFFF_FFFF, 48, 4, 1};
        tbl[6] = '{16'h0C01, 32'h0000_0000, 48, 4, 1};
        tbl[7] = '{16'h0123, 32'h0000_0000, 10, 8, 0};
        tbl[8] = '{16'hF5AB, 32'hCAFE_F00D, 48, 8, 1};

        tick(5);
        chk("reset_outputs", 64'({spi_do, r_valid, r_wen, r_addr, r_wdata}), 64'd0);
        reset = 1'b1;
        tick(5);

        foreach (tbl[i]) run_frame(tbl[i].h, tbl[i].d, tbl[i].nbits, tbl[i].gap, tbl[i].exp_n);

        // Reset in the data phase of a write, then clocks with chip select still low.
        strobes.delete();
        spi_ncs = 1'b0;
        tick(HP);
        shift({16'h8C04, 32'hAAAA_5555}, 30, 1'b0, miso, do_bad);
        reset = 1'b0;
        tick(3);
        chk("midframe_reset_outputs", 64'({spi_do, r_valid, r_wen, r_addr, r_wdata}), 64'd0);
        reset = 1'b1;
        m_addr = '0;
        m_wdata = '0;
        tick(2);
        shift({16'h8C04, 32'hAAAA_5555}, 48, 1'b0, miso, do_bad);
        chk("no_strobe_before_ncs_high", 64'(strobes.size()), 64'd0);
        chk("do_after_reset", 64'(do_bad), 64'd0);
        spi_ncs = 1'b1;
        tick(6);
        run_frame(16'h8C04, 32'hDEAD_BEEF, 48, 8, 1);

        for (int k = 0; k < 20; k++) begin
            logic [15:0] h;
            logic [31:0] d;
            int          mode, nb, en;
            h = 16'($urandom);
            d = $urandom;
            mode = $urandom_range(0, 3);
            if (mode < 2) nb = 48;
            else if (mode == 2) nb = 48 + $urandom_range(1, 8);
            else nb = h[15] ? $urandom_range(1, 47) : $urandom_range(1, 15);
            en = h[15] ? int'(nb >= 48) : int'(nb >= 16);
            run_frame(h, d, nb, $urandom_range(4, 10), en);
        end

        chk("strobe_width", 64'(width_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spir.md
SPIR -- requirements
Module: spir

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameters: none; all widths are fixed.
REQ-003 clk  in  1  system clock; all logic is synchronous to its rising edge.
REQ-004 reset  in  1  synchronous reset, active-low: 0 = in reset.
REQ-005 spi_clk  in  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-006 spi_ncs  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-007 spi_di  in  1  SPI data from master (MOSI), MSB first.
REQ-008 spi_do  out  1  SPI data to master (MISO), MSB first, always driven.
REQ-009 r_valid  out  1  register-access strobe, one clk cycle wide.
REQ-010 r_wen  out  1  1 = write, 0 = read; qualified by r_valid.
REQ-011 r_addr  out  12  word address of the access; held stable from strobe until the next frame header completes.
REQ-012 r_wdata  out  32  write data; held stable from strobe until the next write completes.
REQ-013 r_rdata  in  32  read data; combinational from the target, sampled in the r_valid cycle.

Function
REQ-014 spi_clk, spi_ncs and spi_di SHALL each pass through a 2-flop synchroniser into clk. Edge detection SHALL use a third flop on spi_clk.
REQ-015 The master SHALL keep each spi_clk high and low phase at least 4 clk cycles; behaviour is unspecified below this.
REQ-016 spi_ncs high (synchronised) SHALL abort any frame: clear the bit counter and return to state HDR. No strobe is issued for an incomplete frame.
REQ-017 The block SHALL sample spi_di on each detected spi_clk rising edge while spi_ncs is low.
REQ-018 Frame format: a 16-bit header, then 32 data bits, all MSB first.
REQ-019 Header bit 15 = write flag. Bits 14:12 are ignored. Bits 11:0 = address.
REQ-020 States: HDR (bits 0-15), DATA (bits 16-47), DONE (bits after 47 are ignored, spi_do = 0). DONE is left only when spi_ncs goes high.
REQ-021 Write frame: on the 48th rising edge, r_wdata SHALL load the 32 data bits. In the following clk cycle, r_valid=1 and r_wen=1 for exactly one cycle, with r_addr = header[11:0].
REQ-022 Read frame: on the 16th rising edge, r_addr SHALL load header[11:0]. In the following clk cycle, r_valid=1 and r_wen=0 for exactly one cycle, and r_rdata SHALL be captured into a 32-bit output shift register in that same cycle.
REQ-023 Read data phase: on the 16th detected spi_clk falling edge, spi_do SHALL present bit 31 of the captured word. Each later falling edge SHALL shift to the next lower bit. Bit 0 is presented after the 47th falling edge.
REQ-024 spi_do SHALL be 0 during the header, during write frames, in DONE, and while spi_ncs is high.
REQ-025 A write frame SHALL not alter the read shift register. Data bits clocked in during a read frame SHALL be ignored.
REQ-026 The block supports exactly one access per chip-select frame; there is no auto-increment.

Reset
REQ-027 While reset=0: r_valid=0, r_wen=0, r_addr=0, r_wdata=0, spi_do=0, state=HDR, bit counter=0, shift registers=0. Synchroniser flops SHALL reset to spi_ncs=1 and spi_clk=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame without a strobe. After release, the next frame SHALL start only after spi_ncs has been seen high.

Verification
REQ-029 Write frame, header 0x8C04, data 0xDEADBEEF -> exactly one r_valid cycle with r_wen=1, r_addr=0xC04, r_wdata=0xDEADBEEF.
REQ-030 Read frame, header 0x0C01, r_rdata tied to 0x00800001 -> one r_valid cycle with r_wen=0 and r_addr=0xC01; the master shifts in 0x00800001 over the 32 data clocks.
REQ-031 Write frame with spi_ncs raised after 30 bits -> no r_valid pulse. A following complete write to 0x801 with data 0x12345678 strobes correctly.
REQ-032 Write frame followed by 8 extra spi_clk pulses before spi_ncs rises -> exactly one strobe, spi_do stays 0.
REQ-033 reset=0 asserted during the data phase of a write -> no strobe, all outputs 0. After reset=1 and spi_ncs toggled high then low, a full write frame strobes correctly.
REQ-034 Back-to-back read frames of 0x0C00 and 0x0C01, each with spi_ncs high for 4 clk between them -> two strobes, each returning its own r_rdata value.
